// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - execute-stage branch resolution with registered PC redirect
// Evaluates branch conditions from subtract flags, issues redirect to fetch, flushes younger stages.
module branch_resolve #(
  parameter int DRAIN_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  output logic             ex_ready,
  input  logic             ex_branch,
  input  logic             ex_jump,
  input  logic [2:0]       ex_funct3,
  input  logic             Z,
  input  logic             N,
  input  logic             V,
  input  logic             C,
  input  logic [31:0]      ex_target,
  output logic             redirect_valid,
  input  logic             redirect_ready,
  output logic [31:0]      redirect_pc,
  output logic             flush,
  output logic             misalign,
  output logic             illegal_cond,
  output logic [CNT_W-1:0] resolved_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef enum logic [1:0] {IDLE, REDIRECT, DRAIN} state_t;

  // Unused when DRAIN_CYCLES is 0; the DRAIN state is then unreachable.
  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  state_t     state, state_nxt;
  logic [3:0] drain_cnt, drain_cnt_nxt;
  logic       accept, cond, taken, aligned, illegal_hit, redirect_go;

  assign accept      = ex_valid & ex_ready & (ex_branch | ex_jump);
  assign illegal_hit = ex_branch & ~ex_jump & (ex_funct3[2:1] == 2'b01);
  assign taken       = ex_jump | (ex_branch & cond);
  assign aligned     = (ex_target[1:0] == 2'b00);
  assign redirect_go = accept & taken & aligned;

  always_comb begin
    cond = 1'b0;
    case (ex_funct3)
      3'b000:  cond = Z;
      3'b001:  cond = ~Z;
      3'b100:  cond = N ^ V;
      3'b101:  cond = ~(N ^ V);
      3'b110:  cond = ~C;
      3'b111:  cond = C;
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    case (state)
      IDLE: begin
        if (redirect_go) state_nxt = REDIRECT;
      end
      REDIRECT: begin
        if (redirect_ready) begin
          if (DRAIN_CYCLES == 0) begin
            state_nxt = IDLE;
          end else begin
            state_nxt     = DRAIN;
            drain_cnt_nxt = DRAIN_LOAD;
          end
        end
      end
      DRAIN: begin
        if (drain_cnt == 4'd0) state_nxt = IDLE;
        else drain_cnt_nxt = drain_cnt - 4'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      drain_cnt      <= 4'd0;
      ex_ready       <= 1'b1;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'd0;
      flush          <= 1'b0;
      misalign       <= 1'b0;
      illegal_cond   <= 1'b0;
      resolved_cnt   <= '0;
      taken_cnt      <= '0;
    end else begin
      state          <= state_nxt;
      drain_cnt      <= drain_cnt_nxt;
      ex_ready       <= (state_nxt == IDLE);
      redirect_valid <= (state_nxt == REDIRECT);
      flush          <= (state_nxt != IDLE);
      misalign       <= accept & taken & ~aligned;
      illegal_cond   <= accept & illegal_hit;
      if (redirect_go) redirect_pc <= ex_target;
      if (accept) resolved_cnt <= resolved_cnt + CNT_W'(1);
      if (redirect_valid & redirect_ready) taken_cnt <= taken_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// tb/tb_branch_resolve.sv - directed table-driven bench for branch_resolve
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ex_valid = 1'b0, ex_branch = 1'b0, ex_jump = 1'b0;
  logic [2:0]  ex_funct3 = 3'd0;
  logic        fz = 1'b0, fn = 1'b0, fv = 1'b0, fc = 1'b0;
  logic [31:0] ex_target = 32'd0;
  logic        redirect_ready = 1'b1;

  logic        m_ready, m_rv, m_flush, m_mis, m_ill;
  logic [31:0] m_pc, m_res, m_tak;
  logic        w_ready, w_rv, w_flush, w_mis, w_ill;
  logic [31:0] w_pc;
  logic [3:0]  w_res, w_tak;
  logic        d_ready, d_rv, d_flush, d_mis, d_ill;
  logic [31:0] d_pc, d_res, d_tak;

  always #5 clk = ~clk;

  branch_resolve #(.DRAIN_CYCLES(1), .CNT_W(32)) u_main (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ready(m_ready),
    .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_funct3(ex_funct3),
    .Z(fz), .N(fn), .V(fv), .C(fc), .ex_target(ex_target),
    .redirect_valid(m_rv), .redirect_ready(redirect_ready), .redirect_pc(m_pc),
    .flush(m_flush), .misalign(m_mis), .illegal_cond(m_ill),
    .resolved_cnt(m_res), .taken_cnt(m_tak));

  branch_resolve #(.DRAIN_CYCLES(1), .CNT_W(4)) u_wrap (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ready(w_ready),
    .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_funct3(ex_funct3),
    .Z(fz), .N(fn), .V(fv), .C(fc), .ex_target(ex_target),
    .redirect_valid(w_rv), .redirect_ready(redirect_ready), .redirect_pc(w_pc),
    .flush(w_flush), .misalign(w_mis), .illegal_cond(w_ill),
    .resolved_cnt(w_res), .taken_cnt(w_tak));

  branch_resolve #(.DRAIN_CYCLES(0), .CNT_W(32)) u_d0 (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ready(d_ready),
    .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_funct3(ex_funct3),
    .Z(fz), .N(fn), .V(fv), .C(fc), .ex_target(ex_target),
    .redirect_valid(d_rv), .redirect_ready(redirect_ready), .redirect_pc(d_pc),
    .flush(d_flush), .misalign(d_mis), .illegal_cond(d_ill),
    .resolved_cnt(d_res), .taken_cnt(d_tak));

  typedef struct {
    logic        br;
    logic        jmp;
    logic [2:0]  f3;
    logic [3:0]  flags;   // {Z,N,V,C}
    logic [31:0] tgt;
    logic        exp_rv;
    logic        exp_mis;
    logic        exp_ill;
  } vec_t;

  typedef struct {
    logic [2:0]  f3;
    logic [15:0] mask;    // bit i = taken for flags {Z,N,V,C} == i
  } sweep_t;

  int checks = 0;
  int errors = 0;
  int exp_res = 0;
  int exp_tak = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic br, input logic jmp, input logic [2:0] f3,
                       input logic [3:0] fl, input logic [31:0] tgt);
    ex_valid  = 1'b1;
    ex_branch = br;
    ex_jump   = jmp;
    ex_funct3 = f3;
    {fz, fn, fv, fc} = fl;
    ex_target = tgt;
  endtask

  task automatic clear_inputs();
    ex_valid  = 1'b0;
    ex_branch = 1'b0;
    ex_jump   = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (m_ready !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    check("idle_timeout", {31'd0, m_ready}, 32'd1);
  endtask

  vec_t   vecs[11];
  sweep_t sw[6];

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 3'b000, 4'b1000, 32'h0000_0200, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 3'b001, 4'b1000, 32'h0000_0204, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 3'b110, 4'b0000, 32'h0000_0208, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 3'b101, 4'b0110, 32'h0000_020C, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 3'b010, 4'b1111, 32'h0000_0210, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 3'b011, 4'b0000, 32'h0000_0214, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 3'b000, 4'b0000, 32'h0000_0102, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 3'b000, 4'b0000, 32'h0000_0404, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 3'b010, 4'b0000, 32'h0000_0500, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 3'b000, 4'b1000, 32'h0000_0203, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 3'b111, 4'b0000, 32'h0000_0220, 1'b0, 1'b0, 1'b0};
    sw[0] = '{3'b000, 16'hFF00};
    sw[1] = '{3'b001, 16'h00FF};
    sw[2] = '{3'b100, 16'h3C3C};
    sw[3] = '{3'b101, 16'hC3C3};
    sw[4] = '{3'b110, 16'h5555};
    sw[5] = '{3'b111, 16'hAAAA};

    // Reset values
    reset = 1'b1;
    tick();
    tick();
    check("rst_ex_ready", {31'd0, m_ready}, 32'd1);
    check("rst_rv", {31'd0, m_rv}, 32'd0);
    check("rst_pc", m_pc, 32'd0);
    check("rst_flush", {31'd0, m_flush}, 32'd0);
    check("rst_mis", {31'd0, m_mis}, 32'd0);
    check("rst_ill", {31'd0, m_ill}, 32'd0);
    check("rst_res", m_res, 32'd0);
    check("rst_tak", m_tak, 32'd0);
    reset = 1'b0;

    // BEQ taken, ready tied high: latency and drain timing
    redirect_ready = 1'b1;
    apply(1'b1, 1'b0, 3'b000, 4'b1000, 32'h0000_0100);
    tick();
    clear_inputs();
    check("beq_rv_t1", {31'd0, m_rv}, 32'd1);
    check("beq_pc_t1", m_pc, 32'h0000_0100);
    check("beq_flush_t1", {31'd0, m_flush}, 32'd1);
    check("beq_ready_t1", {31'd0, m_ready}, 32'd0);
    check("beq_res_t1", m_res, 32'd1);
    tick();
    check("beq_rv_t2", {31'd0, m_rv}, 32'd0);
    check("beq_flush_t2", {31'd0, m_flush}, 32'd1);
    check("beq_tak_t2", m_tak, 32'd1);
    tick();
    check("beq_flush_t3", {31'd0, m_flush}, 32'd0);
    check("beq_ready_t3", {31'd0, m_ready}, 32'd1);
    exp_res = 1;
    exp_tak = 1;

    // Directed vector table
    for (int i = 0; i < 11; i++) begin
      apply(vecs[i].br, vecs[i].jmp, vecs[i].f3, vecs[i].flags, vecs[i].tgt);
      tick();
      clear_inputs();
      check($sformatf("vec%0d_rv", i), {31'd0, m_rv}, {31'd0, vecs[i].exp_rv});
      check($sformatf("vec%0d_mis", i), {31'd0, m_mis}, {31'd0, vecs[i].exp_mis});
      check($sformatf("vec%0d_ill", i), {31'd0, m_ill}, {31'd0, vecs[i].exp_ill});
      if (vecs[i].exp_rv) check($sformatf("vec%0d_pc", i), m_pc, vecs[i].tgt);
      exp_res++;
      if (vecs[i].exp_rv) exp_tak++;
      wait_idle();
      tick();
      check($sformatf("vec%0d_mis_clr", i), {31'd0, m_mis}, 32'd0);
      check($sformatf("vec%0d_ill_clr", i), {31'd0, m_ill}, 32'd0);
      check($sformatf("vec%0d_res", i), m_res, exp_res);
      check($sformatf("vec%0d_tak", i), m_tak, exp_tak);
    end

    // Full condition sweep
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 16; i++) begin
        apply(1'b1, 1'b0, sw[k].f3, 4'(i), 32'h0000_1000);
        tick();
        clear_inputs();
        check($sformatf("sweep_f3_%0d_flags_%0d", sw[k].f3, i), {31'd0, m_rv}, {31'd0, sw[k].mask[i]});
        exp_res++;
        if (sw[k].mask[i]) exp_tak++;
        wait_idle();
      end
    end
    check("sweep_res", m_res, exp_res);
    check("sweep_tak", m_tak, exp_tak);

    // Backpressure: ready low 5 cycles, competing branch ignored
    redirect_ready = 1'b0;
    apply(1'b1, 1'b0, 3'b000, 4'b1000, 32'h0000_2000);
    tick();
    exp_res++;
    exp_tak++;
    apply(1'b1, 1'b0, 3'b001, 4'b0000, 32'h0000_3000);
    for (int c = 0; c < 6; c++) begin
      check($sformatf("bp_rv_%0d", c), {31'd0, m_rv}, 32'd1);
      check($sformatf("bp_pc_%0d", c), m_pc, 32'h0000_2000);
      check($sformatf("bp_res_%0d", c), m_res, exp_res);
      if (c == 5) begin
        redirect_ready = 1'b1;
        clear_inputs();
      end
      tick();
    end
    check("bp_rv_after", {31'd0, m_rv}, 32'd0);
    check("bp_tak", m_tak, exp_tak);
    wait_idle();
    check("bp_res_final", m_res, exp_res);

    // Reset while a redirect is pending
    redirect_ready = 1'b0;
    apply(1'b0, 1'b1, 3'b000, 4'b0000, 32'h0000_0600);
    tick();
    clear_inputs();
    check("rr_rv_before", {31'd0, m_rv}, 32'd1);
    reset = 1'b1;
    tick();
    check("rr_rv", {31'd0, m_rv}, 32'd0);
    check("rr_flush", {31'd0, m_flush}, 32'd0);
    check("rr_ready", {31'd0, m_ready}, 32'd1);
    check("rr_res", m_res, 32'd0);
    check("rr_tak", m_tak, 32'd0);
    reset = 1'b0;
    redirect_ready = 1'b1;
    tick();
    check("rr_tak_after", m_tak, 32'd0);

    // DRAIN_CYCLES = 0 instance
    apply(1'b0, 1'b1, 3'b000, 4'b0000, 32'h0000_0080);
    tick();
    clear_inputs();
    check("d0_rv_t1", {31'd0, d_rv}, 32'd1);
    check("d0_flush_t1", {31'd0, d_flush}, 32'd1);
    check("d0_pc_t1", d_pc, 32'h0000_0080);
    tick();
    check("d0_rv_h1", {31'd0, d_rv}, 32'd0);
    check("d0_flush_h1", {31'd0, d_flush}, 32'd0);
    check("d0_ready_h1", {31'd0, d_ready}, 32'd1);
    check("d0_tak_h1", d_tak, 32'd1);
    wait_idle();

    // Counter wrap with CNT_W = 4
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int j = 0; j < 16; j++) begin
      wait_idle();
      if (j == 15) begin
        check("wrap_tak_15", {28'd0, w_tak}, 32'd15);
        check("wrap_res_15", {28'd0, w_res}, 32'd15);
      end
      apply(1'b0, 1'b1, 3'b000, 4'b0000, 32'h0000_0100 + 32'(4 * j));
      tick();
      clear_inputs();
    end
    wait_idle();
    check("wrap_tak_0", {28'd0, w_tak}, 32'd0);
    check("wrap_res_0", {28'd0, w_res}, 32'd0);
    check("wrap_main_tak", m_tak, 32'd16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
